// File: rtl/pram_responder.sv
// pram_responder: memory-side end of the palette lookup interface.
// 256 x 32-bit palette store (BG words 0-127, OBJ words 128-255) shared by
// fixed-latency graphics lookups, a CPU read FSM and a CPU write buffer.
// Optional feature macro: PRAM_STALL_CNT_EN (arbitration stall counter).
module pram_responder #(
   parameter int WBUF_DEPTH = 4
) (
   input  logic        clk,
   input  logic        clear,
   input  logic        gfx_req,
   input  logic [31:0] gfx_addr,
   input  logic        gfx_is_obj,
   output logic [31:0] gfx_data,
   output logic        gfx_valid,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [9:0]  cpu_addr,
   input  logic [3:0]  cpu_be,
   input  logic [31:0] cpu_wdata,
   output logic        cpu_wready,
   output logic [31:0] cpu_rdata,
   output logic        cpu_ack,
   output logic [15:0] stall_cnt
);

   localparam int PTR_W = (WBUF_DEPTH > 1) ? $clog2(WBUF_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {
      IDLE,
      DRAIN,
      ISSUE,
      RESP
   } state_t;

   state_t state;
   state_t state_next;

   logic [31:0] mem [0:255];

   logic [7:0]  fifo_idx  [WBUF_DEPTH];
   logic [3:0]  fifo_be   [WBUF_DEPTH];
   logic [31:0] fifo_data [WBUF_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;

   logic [7:0] rd_idx;
   logic [7:0] gfx_idx;
   logic       fifo_empty;
   logic       fifo_full;
   logic       push;
   logic       pop;
   logic       cpu_rd;
   logic       unused_addr_bits;

   assign gfx_idx    = {gfx_is_obj, gfx_addr[8:2]};
   assign fifo_empty = (count == '0);
   assign fifo_full  = (count == CNT_W'(WBUF_DEPTH));

   // Writes are only taken while the read FSM is idle, so a pending read
   // never sees a write that arrived after it.
   assign cpu_wready = ~fifo_full & (state == IDLE);
   assign push       = cpu_req & cpu_we & cpu_wready;

   // One array access per cycle: graphics, then CPU read, then drain.
   assign cpu_rd = ~gfx_req & (state == ISSUE);
   assign pop    = ~gfx_req & ~cpu_rd & ~fifo_empty;

   assign cpu_ack = (state == RESP);

   assign unused_addr_bits = ^{gfx_addr[31:9], gfx_addr[1:0], cpu_addr[1:0]};

   // Write buffer payload storage; validity is tracked by the pointers.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_idx[wr_ptr]  <= cpu_addr[9:2];
         fifo_be[wr_ptr]   <= cpu_be;
         fifo_data[wr_ptr] <= cpu_wdata;
      end
   end

   // Write buffer pointers and occupancy; clear discards buffered writes.
   always_ff @(posedge clk) begin
      if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Drain the head entry into the array as a byte-enable merge.
   always_ff @(posedge clk) begin
      if (!clear && pop) begin
         for (int b = 0; b < 4; b++) begin
            if (fifo_be[rd_ptr][b]) begin
               mem[fifo_idx[rd_ptr]][8*b +: 8] <= fifo_data[rd_ptr][8*b +: 8];
            end
         end
      end
   end

   // Registered read ports for graphics lookups and CPU reads.
   always_ff @(posedge clk) begin
      if (clear) begin
         gfx_valid <= 1'b0;
         gfx_data  <= '0;
         cpu_rdata <= '0;
      end else begin
         gfx_valid <= gfx_req;
         if (gfx_req) begin
            gfx_data <= mem[gfx_idx];
         end
         if (cpu_rd) begin
            cpu_rdata <= mem[rd_idx];
         end
      end
   end

   // Read FSM state register and latched read index.
   always_ff @(posedge clk) begin
      if (clear) begin
         state  <= IDLE;
         rd_idx <= '0;
      end else begin
         state <= state_next;
         if (state == IDLE && cpu_req && !cpu_we) begin
            rd_idx <= cpu_addr[9:2];
         end
      end
   end

   // Read FSM next state: wait for older writes, then wait for a free slot.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (cpu_req && !cpu_we) state_next = DRAIN;
         DRAIN:   if (fifo_empty) state_next = ISSUE;
         ISSUE:   if (!gfx_req) state_next = RESP;
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

`ifdef PRAM_STALL_CNT_EN
   logic [15:0] stall_q;

   // Count cycles where CPU work is blocked by a graphics lookup.
   always_ff @(posedge clk) begin
      if (clear) begin
         stall_q <= '0;
      end else if ((!fifo_empty || state == ISSUE) && gfx_req && stall_q != 16'hFFFF) begin
         stall_q <= stall_q + 16'd1;
      end
   end

   assign stall_cnt = stall_q;
`else
   assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pram_responder.sv
// Self-checking bench for pram_responder: directed scenarios plus randomized
// write/read/lookup traffic checked against a transaction-level memory model.
module tb_pram_responder;

   logic        clk;
   logic        clear;
   logic        gfx_req;
   logic [31:0] gfx_addr;
   logic        gfx_is_obj;
   logic [31:0] gfx_data;
   logic        gfx_valid;
   logic        cpu_req;
   logic        cpu_we;
   logic [9:0]  cpu_addr;
   logic [3:0]  cpu_be;
   logic [31:0] cpu_wdata;
   logic        cpu_wready;
   logic [31:0] cpu_rdata;
   logic        cpu_ack;
   logic [15:0] stall_cnt;

   int tests_run    = 0;
   int tests_failed = 0;

   logic [31:0] model_mem [256];

   pram_responder #(.WBUF_DEPTH(4)) dut (
      .clk        (clk),
      .clear      (clear),
      .gfx_req    (gfx_req),
      .gfx_addr   (gfx_addr),
      .gfx_is_obj (gfx_is_obj),
      .gfx_data   (gfx_data),
      .gfx_valid  (gfx_valid),
      .cpu_req    (cpu_req),
      .cpu_we     (cpu_we),
      .cpu_addr   (cpu_addr),
      .cpu_be     (cpu_be),
      .cpu_wdata  (cpu_wdata),
      .cpu_wready (cpu_wready),
      .cpu_rdata  (cpu_rdata),
      .cpu_ack    (cpu_ack),
      .stall_cnt  (stall_cnt)
   );

   // Free-running clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Counts one comparison and reports it when it does not hold
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mergeBe(input logic [31:0] old, input logic [3:0] be, input logic [31:0] d);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) begin
         if (be[b]) r[8*b +: 8] = d[8*b +: 8];
      end
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drives one cycle of inputs; every lookup must be answered next cycle
   task automatic applyStimulus(input logic g_req, input logic [31:0] g_addr, input logic g_obj,
                                input logic c_req, input logic c_we, input logic [9:0] c_addr,
                                input logic [3:0] c_be, input logic [31:0] c_wdata);
      clear      = 1'b0;
      gfx_req    = g_req;
      gfx_addr   = g_addr;
      gfx_is_obj = g_obj;
      cpu_req    = c_req;
      cpu_we     = c_we;
      cpu_addr   = c_addr;
      cpu_be     = c_be;
      cpu_wdata  = c_wdata;
      tick();
      checkOutput("gfx_valid", {31'b0, gfx_valid}, {31'b0, g_req});
   endtask

   task automatic applyIdle();
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 10'h0, 4'h0, 32'h0);
   endtask

   task automatic applyClear(input logic g_req);
      clear      = 1'b1;
      gfx_req    = g_req;
      gfx_addr   = 32'h0;
      gfx_is_obj = 1'b0;
      cpu_req    = 1'b0;
      cpu_we     = 1'b0;
      tick();
      clear      = 1'b0;
   endtask

   // Posts one write, retrying while the buffer refuses it
   task automatic cpuWrite(input logic [7:0] idx, input logic [3:0] be, input logic [31:0] data,
                           input bit noise, input bit commit);
      bit   done = 0;
      logic acc;
      logic g;
      for (int i = 0; i < 100 && !done; i++) begin
         acc = cpu_wready;
         g   = noise && ($urandom_range(3) == 0);
         applyStimulus(g, $urandom, 1'($urandom_range(1)), 1'b1, 1'b1,
                       {idx, 2'($urandom_range(3))}, be, data);
         if (acc) done = 1;
      end
      if (!done) checkOutput("wr_timeout", 32'd0, 32'd1);
      else if (commit) model_mem[idx] = mergeBe(model_mem[idx], be, data);
   endtask

   // Issues one read and waits for its acknowledge within a cycle budget
   task automatic cpuRead(input logic [7:0] idx, input bit noise);
      bit   got = 0;
      logic g;
      g = noise && ($urandom_range(2) == 0);
      applyStimulus(g, $urandom, 1'($urandom_range(1)), 1'b1, 1'b0, {idx, 2'b00}, 4'h0, 32'h0);
      for (int i = 0; i < 300 && !got; i++) begin
         if (cpu_ack) begin
            got = 1;
         end else begin
            g = noise && ($urandom_range(2) == 0);
            applyStimulus(g, $urandom, 1'($urandom_range(1)), 1'b0, 1'b0, 10'h0, 4'h0, 32'h0);
         end
      end
      if (!got) begin
         checkOutput("rd_timeout", 32'd0, 32'd1);
      end else begin
         checkOutput("cpu_rdata", cpu_rdata, model_mem[idx]);
         applyIdle();
         checkOutput("ack_pulse", {31'b0, cpu_ack}, 32'd0);
      end
   endtask

   // One graphics lookup with random junk in the ignored address bits
   task automatic gfxRead(input logic [7:0] idx);
      logic [31:0] a;
      a      = $urandom;
      a[8:2] = idx[6:0];
      applyStimulus(1'b1, a, idx[7], 1'b0, 1'b0, 10'h0, 4'h0, 32'h0);
      checkOutput("gfx_data", gfx_data, model_mem[idx]);
   endtask

   initial begin
      clear      = 1'b1;
      gfx_req    = 1'b0;
      gfx_addr   = 32'h0;
      gfx_is_obj = 1'b0;
      cpu_req    = 1'b0;
      cpu_we     = 1'b0;
      cpu_addr   = 10'h0;
      cpu_be     = 4'h0;
      cpu_wdata  = 32'h0;

      applyClear(1'b0);
      applyClear(1'b1);
      checkOutput("rst_gfx_valid", {31'b0, gfx_valid}, 32'd0);
      checkOutput("rst_gfx_data", gfx_data, 32'd0);
      checkOutput("rst_cpu_ack", {31'b0, cpu_ack}, 32'd0);
      checkOutput("rst_cpu_rdata", cpu_rdata, 32'd0);
      checkOutput("rst_wready", {31'b0, cpu_wready}, 32'd1);
      checkOutput("rst_stall", {16'b0, stall_cnt}, 32'd0);

      for (int i = 0; i < 256; i++) cpuWrite(8'(i), 4'hF, $urandom, 1'b0, 1'b1);
      cpuRead(8'd0, 1'b0);

      // Graphics read of a freshly written BG word, then hold behaviour
      cpuWrite(8'd0, 4'hF, 32'h7FFF_001F, 1'b0, 1'b1);
      applyIdle();
      applyIdle();
      applyStimulus(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 10'h0, 4'h0, 32'h0);
      checkOutput("gfx_first", gfx_data, 32'h7FFF_001F);
      applyIdle();
      checkOutput("gfx_hold", gfx_data, 32'h7FFF_001F);

      // OBJ versus BG palette selection for the same lookup address
      cpuWrite(8'h81, 4'hF, 32'h1234_5678, 1'b0, 1'b1);
      cpuWrite(8'h01, 4'hF, 32'hAAAA_BBBB, 1'b0, 1'b1);
      applyIdle();
      applyIdle();
      applyStimulus(1'b1, 32'h6, 1'b1, 1'b0, 1'b0, 10'h0, 4'h0, 32'h0);
      checkOutput("gfx_obj", gfx_data, 32'h1234_5678);
      applyStimulus(1'b1, 32'h6, 1'b0, 1'b0, 1'b0, 10'h0, 4'h0, 32'h0);
      checkOutput("gfx_bg", gfx_data, 32'hAAAA_BBBB);

      // Byte-enable merge observed through a CPU read
      cpuWrite(8'h00, 4'hF, 32'h1122_3344, 1'b0, 1'b1);
      cpuWrite(8'h00, 4'b0101, 32'hAABB_CCDD, 1'b0, 1'b1);
      cpuRead(8'h00, 1'b0);
      checkOutput("be_merge", cpu_rdata, 32'h11BB_33DD);

      // Buffer full under continuous lookups, then ordered drain and read
      applyClear(1'b0);
      checkOutput("clr_stall", {16'b0, stall_cnt}, 32'd0);
      begin
         logic [7:0]  idxs [4];
         logic [31:0] d;
         bit          got;
         idxs = '{8'd10, 8'd11, 8'd12, 8'd10};
         for (int i = 0; i < 4; i++) begin
            d = $urandom;
            checkOutput("full_wready_pre", {31'b0, cpu_wready}, 32'd1);
            applyStimulus(1'b1, $urandom, 1'b0, 1'b1, 1'b1, {idxs[i], 2'b00}, 4'hF, d);
            model_mem[idxs[i]] = d;
         end
         checkOutput("full_wready", {31'b0, cpu_wready}, 32'd0);
         applyStimulus(1'b1, $urandom, 1'b0, 1'b1, 1'b0, {8'd10, 2'b00}, 4'h0, 32'h0);
         got = 0;
         for (int i = 0; i < 50 && !got; i++) begin
            applyIdle();
            if (cpu_ack) got = 1;
         end
         checkOutput("full_ack", {31'b0, got}, 32'd1);
         checkOutput("full_rdata", cpu_rdata, model_mem[10]);
`ifdef PRAM_STALL_CNT_EN
         checkOutput("stall_cnt", {16'b0, stall_cnt}, 32'd4);
`else
         checkOutput("stall_cnt", {16'b0, stall_cnt}, 32'd0);
`endif
         applyIdle();
      end

      // Read parked in ISSUE while lookups hold the array for 5 cycles
      applyStimulus(1'b1, $urandom, 1'b0, 1'b1, 1'b0, {8'd11, 2'b00}, 4'h0, 32'h0);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, $urandom, 1'b0, 1'b0, 1'b0, 10'h0, 4'h0, 32'h0);
         checkOutput("prio_no_ack", {31'b0, cpu_ack}, 32'd0);
      end
      applyIdle();
      checkOutput("prio_ack", {31'b0, cpu_ack}, 32'd1);
      checkOutput("prio_rdata", cpu_rdata, model_mem[11]);
      applyIdle();
      checkOutput("prio_ack_pulse", {31'b0, cpu_ack}, 32'd0);

      // Clear with buffered writes and a read waiting in DRAIN
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, $urandom, 1'b0, 1'b1, 1'b1, {8'(20 + i), 2'b00}, 4'hF, $urandom);
      end
      applyStimulus(1'b1, $urandom, 1'b0, 1'b1, 1'b0, {8'd20, 2'b00}, 4'h0, 32'h0);
      applyClear(1'b1);
      checkOutput("clr_gfx_valid", {31'b0, gfx_valid}, 32'd0);
      checkOutput("clr_gfx_data", gfx_data, 32'd0);
      checkOutput("clr_ack", {31'b0, cpu_ack}, 32'd0);
      checkOutput("clr_wready", {31'b0, cpu_wready}, 32'd1);
      for (int i = 0; i < 8; i++) begin
         applyIdle();
         checkOutput("clr_no_ack", {31'b0, cpu_ack}, 32'd0);
      end
      for (int i = 0; i < 3; i++) gfxRead(8'(20 + i));

      // Randomized traffic against the memory model
      for (int it = 0; it < 40; it++) begin
         int nw;
         nw = $urandom_range(5);
         for (int w = 0; w < nw; w++) begin
            logic [7:0] wi;
            wi = ($urandom_range(1) == 0) ? 8'($urandom_range(15)) : 8'($urandom);
            cpuWrite(wi, 4'($urandom), $urandom, 1'b1, 1'b1);
         end
         cpuRead(($urandom_range(1) == 0) ? 8'($urandom_range(15)) : 8'($urandom), 1'b1);
         for (int g = 0; g < int'($urandom_range(4, 1)); g++) begin
            gfxRead(($urandom_range(1) == 0) ? 8'($urandom_range(15)) : 8'($urandom));
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/pram_responder.md
Name: pram_responder

Overview:
- Palette RAM (PRAM) responder: the memory-side end of the palette lookup interface driven by the graphics priority evaluator.
- Holds 1 KB of palette storage as 256 x 32-bit words: BG palette in words 0-127, OBJ palette in words 128-255.
- Serves graphics lookups with a fixed 1-cycle latency and absolute priority.
- Arbitrates CPU palette writes (through a write buffer) and CPU reads into the idle cycles between graphics lookups.

Parameters:
- WBUF_DEPTH, 4, CPU write buffer entries; power of 2, 2..16.

Ports:
- clk  in  1  system clock; all logic on posedge.
- clear  in  1  synchronous, active-high reset.
- gfx_req  in  1  graphics lookup strobe (evaluator send_address_1 | send_address_2).
- gfx_addr  in  32  byte address within the selected palette; bits [8:2] used, all others ignored.
- gfx_is_obj  in  1  1 = OBJ palette, 0 = BG palette.
- gfx_data  out  32  full word read; the requester selects the halfword using its own address[1].
- gfx_valid  out  1  gfx_data valid this cycle.
- cpu_req  in  1  CPU access request.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  10  CPU byte address; word index = cpu_addr[9:2].
- cpu_be  in  4  write byte enables; bit n covers data[8n+7:8n].
- cpu_wdata  in  32  write data.
- cpu_wready  out  1  write is accepted this cycle when cpu_req & cpu_we & cpu_wready.
- cpu_rdata  out  32  read data.
- cpu_ack  out  1  one-cycle pulse: cpu_rdata valid.
- stall_cnt  out  16  arbitration stall counter (see Optional Feature).

Behaviour:
- Storage is single-port: exactly one array access per cycle. clear does not initialise the array.
- Graphics index = {gfx_is_obj, gfx_addr[8:2]}.
- Graphics access:
  - gfx_req=1 in cycle N reads the array in cycle N.
  - In cycle N+1, gfx_valid=1 and gfx_data holds the word.
  - Back-to-back requests are served every cycle.
  - gfx_data holds its last value when gfx_valid=0.
- Access priority per cycle: graphics read > CPU read issue > write-buffer drain.
- Write buffer:
  - FIFO of {index, be, wdata}.
  - cpu_wready = ~full & (state==IDLE). Full is evaluated from state at the start of the cycle; no same-cycle push-through when full.
  - Head entry drains in any cycle with no gfx_req and no read issue.
  - Drain is a byte-enable merge into the stored word; be=0000 drains with no effect.
  - Push and pop in the same cycle is legal, and occupancy is unchanged.
- Read FSM (state register, reset IDLE):
  - IDLE: on cpu_req & ~cpu_we, latch the index and go to DRAIN. Any write presented in that same cycle is not accepted.
  - DRAIN: wait until the FIFO is empty (preserves write-then-read order). Then go to ISSUE; if already empty, go to ISSUE next cycle.
  - ISSUE: if gfx_req=0, read the array and go to RESP; otherwise stay.
  - RESP: cpu_ack=1, cpu_rdata=word, go to IDLE.
  - cpu_req is ignored outside IDLE.
- Reset values: gfx_valid=0, gfx_data=0, cpu_ack=0, cpu_rdata=0, FIFO empty, state=IDLE, stall_cnt=0.
- Reset mid-operation:
  - clear wins over all events.
  - Buffered writes are discarded and any in-flight read is aborted with no ack.
  - A gfx_req in the same cycle as clear produces no gfx_valid.
- Continuous gfx_req starves the CPU. No starvation timeout; the scanline renderer guarantees idle cycles.

Optional Feature:
- Macro: PRAM_STALL_CNT_EN.
- Defined: stall_cnt increments by 1 each cycle where (FIFO non-empty or state==ISSUE) and gfx_req=1. It saturates at 16'hFFFF and is cleared by clear.
- Undefined: stall_cnt is tied to 0 and no counter logic is generated.

Test Plan:
- Graphics read:
  - Write word 0x7FFF_001F at cpu_addr 0x000, drain, then gfx_req with gfx_addr=0x0, gfx_is_obj=0.
  - Required: gfx_valid exactly 1 cycle later, gfx_data=0x7FFF001F.
- OBJ select:
  - Write 0x1234_5678 at cpu_addr 0x204 and 0xAAAA_BBBB at 0x004.
  - gfx_addr=0x6, gfx_is_obj=1 -> gfx_data=0x12345678.
  - gfx_is_obj=0 -> gfx_data=0xAAAABBBB.
- Byte enables:
  - Word 0x0 holds 0x11223344; write be=4'b0101, wdata=0xAABBCCDD.
  - CPU read of 0x0 -> cpu_ack, cpu_rdata=0x11BB33DD.
- FIFO full and ordering (WBUF_DEPTH=4):
  - Hold gfx_req=1 and push 4 writes -> cpu_wready=0 after the 4th push.
  - Issue a read to the last-written address; release gfx_req.
  - Required: FIFO drains, then cpu_ack returns the newest data. stall_cnt>0 when PRAM_STALL_CNT_EN is defined, 0 otherwise.
- Priority:
  - Read pending in ISSUE while gfx_req is held for 5 cycles.
  - Required: gfx_valid on each of 5 consecutive cycles; cpu_ack on the 2nd cycle after gfx_req drops (ISSUE read, then RESP).
- Reset mid-operation:
  - Assert clear with 3 buffered writes and a read in DRAIN.
  - Required: no cpu_ack, cpu_wready=1 the next cycle, and the target words are unchanged.
